// File: rtl/block_deformat_pkg.sv
// Shared definitions for the block-format receiver: format codes, index bounds, FSM states.
package block_deformat_pkg;

  localparam logic FMT_9 = 1'b0;
  localparam logic FMT_4 = 1'b1;

  localparam logic [3:0] FIRST_IDX_9 = 4'd1;
  localparam logic [3:0] LAST_IDX_9  = 4'd9;
  localparam logic [3:0] FIRST_IDX_4 = 4'd0;
  localparam logic [3:0] LAST_IDX_4  = 4'd3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  function automatic logic [3:0] first_idx(input logic fmt);
    return (fmt == FMT_4) ? FIRST_IDX_4 : FIRST_IDX_9;
  endfunction

  function automatic logic [3:0] last_idx(input logic fmt);
    return (fmt == FMT_4) ? LAST_IDX_4 : LAST_IDX_9;
  endfunction

endpackage

// File: rtl/block_index_tracker.sv
// Tracks the next legal block index and the format latched at block start.
module block_index_tracker
  import block_deformat_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_advance,
  input  logic       i_fmt,
  input  logic [3:0] i_index,
  output logic       o_is_expected,
  output logic       o_is_last,
  output logic       o_fmt
);

  logic [3:0] r_expected;
  logic       r_fmt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_expected <= '0;
      r_fmt      <= FMT_9;
    end else if (i_load) begin
      r_fmt      <= i_fmt;
      r_expected <= first_idx(i_fmt) + 4'd1;
    end else if (i_advance) begin
      r_expected <= r_expected + 4'd1;
    end
  end

  assign o_is_expected = (i_index == r_expected);
  assign o_is_last     = (r_expected == last_idx(r_fmt));
  assign o_fmt         = r_fmt;

endmodule

// File: rtl/block_deformat.sv
// Block-format stream receiver: validates index/flag sequence and sums each block's words.
module block_deformat
  import block_deformat_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int SUM_LENGTH  = WORD_LENGTH + 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   switch_format,
  input  logic [3:0]             index_in,
  input  logic                   flag_in,
  input  logic [WORD_LENGTH-1:0] data_in,
  output logic                   block_valid,
  output logic                   block_error,
  output logic [SUM_LENGTH-1:0]  block_sum,
  output logic [3:0]             words_received,
  output logic                   busy
);

  state_t                r_state;
  logic [SUM_LENGTH-1:0] r_acc;
  logic [SUM_LENGTH-1:0] r_sum;
  logic [3:0]            r_words;
  logic                  r_valid;
  logic                  r_error;

  logic                  w_is_expected;
  logic                  w_is_last;
  logic                  w_fmt;
  logic                  w_start;
  logic                  w_match;
  logic                  w_advance;
  logic                  w_finish;
  logic [SUM_LENGTH-1:0] w_data_ext;

  assign w_data_ext = {{(SUM_LENGTH-WORD_LENGTH){1'b0}}, data_in};

  // A first index carrying the end flag would be a one-word block, which is illegal.
  assign w_start   = enable && (r_state == ST_IDLE) &&
                     (index_in == first_idx(switch_format)) && !flag_in;
  assign w_match   = enable && (r_state == ST_COLLECT) &&
                     w_is_expected && (switch_format == w_fmt);
  assign w_advance = w_match && !w_is_last && !flag_in;
  assign w_finish  = w_match && w_is_last && flag_in;

  block_index_tracker u_tracker (
    .clk           (clk),
    .reset         (reset),
    .i_load        (w_start),
    .i_advance     (w_advance),
    .i_fmt         (switch_format),
    .i_index       (index_in),
    .o_is_expected (w_is_expected),
    .o_is_last     (w_is_last),
    .o_fmt         (w_fmt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_sum   <= '0;
      r_words <= '0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      if (enable) begin
        if (r_state == ST_IDLE) begin
          if (w_start) begin
            r_state <= ST_COLLECT;
            r_acc   <= w_data_ext;
            r_words <= 4'd1;
          end else begin
            r_error <= 1'b1;
          end
        end else begin
          if (w_advance) begin
            r_acc   <= r_acc + w_data_ext;
            r_words <= r_words + 4'd1;
          end else if (w_finish) begin
            r_sum   <= r_acc + w_data_ext;
            r_valid <= 1'b1;
            r_acc   <= '0;
            r_words <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_error <= 1'b1;
            r_acc   <= '0;
            r_words <= '0;
            r_state <= ST_IDLE;
          end
        end
      end
    end
  end

  assign block_valid    = r_valid;
  assign block_error    = r_error;
  assign block_sum      = r_sum;
  assign words_received = r_words;
  assign busy           = (r_state == ST_COLLECT);

endmodule

// File: tb/tb_block_deformat.sv
// Self-checking bench for block_deformat: table vectors, directed corner sequences, random traffic vs a queue model.
module tb_block_deformat;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        switch_format;
  logic [3:0]  index_in;
  logic        flag_in;
  logic [7:0]  data_in;
  logic        block_valid;
  logic        block_error;
  logic [11:0] block_sum;
  logic [3:0]  words_received;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  block_deformat #(.WORD_LENGTH(8), .SUM_LENGTH(12)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .switch_format  (switch_format),
    .index_in       (index_in),
    .flag_in        (flag_in),
    .data_in        (data_in),
    .block_valid    (block_valid),
    .block_error    (block_error),
    .block_sum      (block_sum),
    .words_received (words_received),
    .busy           (busy)
  );

  // Reference model: the current block is the queue of data words accepted so far.
  logic [7:0] m_blk[$];
  bit         m_fmt;
  bit         e_valid, e_err;
  int         e_sum;

  function automatic int first_of(bit fmt); return fmt ? 0 : 1; endfunction
  function automatic int last_of(bit fmt);  return fmt ? 3 : 9; endfunction

  function automatic void model_reset();
    m_blk.delete();
    e_valid = 0; e_err = 0; e_sum = 0; m_fmt = 0;
  endfunction

  function automatic void model_step(bit en, bit sw, int idx, bit flag, int d);
    int want;
    int s;
    e_valid = 0;
    e_err   = 0;
    if (!en) return;
    if (m_blk.size() == 0) begin
      if (idx == first_of(sw) && !flag) begin
        m_fmt = sw;
        m_blk.push_back(d[7:0]);
      end else begin
        e_err = 1;
      end
    end else begin
      want = first_of(m_fmt) + m_blk.size();
      if (sw != m_fmt || idx != want || flag != (want == last_of(m_fmt))) begin
        e_err = 1;
        m_blk.delete();
      end else begin
        m_blk.push_back(d[7:0]);
        if (want == last_of(m_fmt)) begin
          s = 0;
          foreach (m_blk[i]) s += int'(m_blk[i]);
          e_sum   = s;
          e_valid = 1;
          m_blk.delete();
        end
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, int'(block_valid), int'(e_valid));
    chk({tag, ".error"}, int'(block_error), int'(e_err));
    chk({tag, ".sum"},   int'(block_sum),   e_sum);
    chk({tag, ".words"}, int'(words_received), m_blk.size());
    chk({tag, ".busy"},  int'(busy), int'(m_blk.size() != 0));
  endtask

  // Drives at the falling edge, clocks once, returns at the next falling edge.
  task automatic step(input bit en, input bit sw, input int idx, input bit flag, input int d);
    enable = en; switch_format = sw; index_in = idx[3:0]; flag_in = flag; data_in = d[7:0];
    @(posedge clk);
    model_step(en, sw, idx, flag, d);
    @(negedge clk);
  endtask

  task automatic send(input string tag, input bit sw, input int idx, input bit flag, input int d);
    step(1'b1, sw, idx, flag, d);
    check_model(tag);
  endtask

  typedef struct {
    bit en; bit sw; int idx; bit flag; int d;
    bit xv; bit xe; int xsum; int xwords; bit xbusy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    for (int i = 1; i <= 9; i++)
      tbl[i-1] = '{en:1, sw:0, idx:i, flag:(i == 9), d:i,
                   xv:(i == 9), xe:0, xsum:((i == 9) ? 45 : 0),
                   xwords:((i == 9) ? 0 : i), xbusy:(i != 9)};
    tbl[9] = '{en:0, sw:1, idx:0, flag:0, d:0, xv:0, xe:0, xsum:45, xwords:0, xbusy:0};

    reset = 1'b1; enable = 0; switch_format = 0; index_in = 0; flag_in = 0; data_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset");
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].sw, tbl[i].idx, tbl[i].flag, tbl[i].d);
      chk("tbl.valid", int'(block_valid), int'(tbl[i].xv));
      chk("tbl.error", int'(block_error), int'(tbl[i].xe));
      chk("tbl.sum",   int'(block_sum),   tbl[i].xsum);
      chk("tbl.words", int'(words_received), tbl[i].xwords);
      chk("tbl.busy",  int'(busy), int'(tbl[i].xbusy));
    end

    for (int i = 0; i <= 3; i++) send("fmt4_ff", 1, i, i == 3, 255);
    chk("fmt4_ff.sum_const", int'(block_sum), 1020);

    send("skip", 0, 1, 0, 7);
    send("skip", 0, 2, 0, 7);
    send("skip", 0, 4, 0, 7);
    chk("skip.err_const", int'(block_error), 1);
    for (int i = 1; i <= 9; i++) send("resync", 0, i, i == 9, 10 * i);
    chk("resync.valid_const", int'(block_valid), 1);
    chk("resync.sum_const", int'(block_sum), 450);

    send("early_flag", 1, 0, 0, 1);
    send("early_flag", 1, 1, 0, 1);
    send("early_flag", 1, 2, 1, 1);
    chk("early_flag.err_const", int'(block_error), 1);
    for (int i = 0; i <= 3; i++) send("no_flag", 1, i, 0, 2);
    chk("no_flag.err_const", int'(block_error), 1);

    send("first_flag", 0, 1, 1, 5);
    send("idle_junk", 1, 2, 0, 5);
    step(0, 1, 0, 0, 0);
    check_model("gap");

    for (int i = 1; i <= 4; i++) send("swfmt", 0, i, 0, 3);
    step(0, 1, 5, 0, 3);
    check_model("swfmt_hold");
    send("swfmt", 1, 5, 0, 3);
    chk("swfmt.err_const", int'(block_error), 1);
    chk("swfmt.words_const", int'(words_received), 0);

    for (int i = 0; i <= 3; i++) send("b2b1", 1, i, i == 3, i + 1);
    chk("b2b1.sum_const", int'(block_sum), 10);
    for (int i = 0; i <= 3; i++) send("b2b2", 1, i, i == 3, 10 * (i + 1));
    chk("b2b2.sum_const", int'(block_sum), 100);
    send("b2b3", 1, 0, 0, 9);
    send("b2b3", 1, 1, 0, 9);
    reset = 1'b1;
    #1;
    model_reset();
    check_model("midreset");
    @(negedge clk);
    reset = 1'b0;
    check_model("postreset");

    for (int n = 0; n < 1500; n++) begin
      bit en, sw, flag;
      int idx, d;
      en = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 255);
      if ($urandom_range(0, 99) < 88) begin
        if (m_blk.size() == 0) begin
          sw = $urandom_range(0, 1);
          idx = first_of(sw);
          flag = 0;
        end else begin
          sw = m_fmt;
          idx = first_of(m_fmt) + m_blk.size();
          flag = (idx == last_of(m_fmt));
        end
      end else begin
        sw   = $urandom_range(0, 1);
        idx  = $urandom_range(0, 15);
        flag = $urandom_range(0, 1);
      end
      step(en, sw, idx, flag, d);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  always @(negedge clk) begin
    if (block_valid && block_error) begin
      n_checks++;
      n_errors++;
      $display("FAIL exclusive_pulses: valid=%0d error=%0d required not both high", block_valid, block_error);
    end
  end

endmodule

// File: doc/block_deformat.md
# block_deformat

Receiving end of the block-format stream. It consumes words tagged with the block index and end-of-block flag that the block formatter produces, in either 9-word or 4-word format. It checks that the index sequence and flag placement are legal and accumulates the block's data words. It reports each completed block as a one-cycle pulse with its sum, or reports a sequence error. It sits downstream of the formatter and feeds block-level consumers (display/accumulator logic).

## Interface
- WORD_LENGTH, 8, width of each data word
- SUM_LENGTH, WORD_LENGTH+4, width of block sum; 9 words max, so no overflow
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- enable  input  1  word strobe; the other inputs are valid only when enable=1
- switch_format  input  1  0 = 9-word format, 1 = 4-word format
- index_in  input  4  block index of the current word
- flag_in  input  1  end-of-block marker; must accompany the last index
- data_in  input  WORD_LENGTH  data word
- block_valid  output  1  one-cycle pulse: block completed without error
- block_error  output  1  one-cycle pulse: sequence violation detected
- block_sum  output  SUM_LENGTH  unsigned sum of the completed block; held until the next block_valid
- words_received  output  4  words accepted in the current block; 0 when idle
- busy  output  1  high while in COLLECT

## Operation
- Legal sequences:
  - 9-word format: indices 1,2,…,9, with flag_in=1 only on index 9.
  - 4-word format: indices 0,1,2,3, with flag_in=1 only on index 3.
- FSM states: IDLE and COLLECT. Format is latched on the first word of a block.
- IDLE, enable=1, index_in = first index of the current switch_format:
  - latch format; accumulator ← data_in; words_received ← 1; expected ← first+1; go to COLLECT.
- IDLE, enable=1, any other index: pulse block_error and stay in IDLE. Resync happens only on a first index.
- COLLECT, enable=1:
  - index_in = expected, flag_in=0, not last index: accumulate; expected+1; words_received+1.
  - index_in = expected = last index, flag_in=1: block_sum ← accumulator + data_in; pulse block_valid; go to IDLE.
  - Any mismatch is an error: wrong index, flag_in on a non-last index, missing flag on the last index, or switch_format differing from the latched format. On error, pulse block_error, clear the accumulator and go to IDLE. The offending word is not reused as a new block start.
- COLLECT, enable=0: hold all state. No timeout.
- Single-word blocks do not exist; flag_in on a first index in IDLE is an error.
- Unsigned arithmetic; the accumulator is SUM_LENGTH wide and zero-extends data_in.

## Timing
- Reset values: block_valid=0, block_error=0, block_sum=0, words_received=0, busy=0, state=IDLE.
- All outputs are registered.
- Latency: block_valid/block_error assert the cycle after the clock edge that samples the last or offending word. block_sum updates on that same edge.
- Back-to-back blocks: a first-index word may arrive in the cycle immediately after the last word. It is accepted while block_valid is high, with no bubble required.
- block_valid and block_error are never high in the same cycle.
- Reset mid-block discards the partial block with no pulse.
- switch_format is ignored while enable=0.

## Structure
- Shared package holds:
  - format encodings FMT_9=1'b0, FMT_4=1'b1;
  - first/last indices: 4'd1/4'd9 and 4'd0/4'd3;
  - state encoding.
- One natural sub-module, block_index_tracker: holds the expected-index counter and latched format, and outputs is_expected and is_last. The top level holds the FSM, accumulator and output registers.

## Test plan
- 9-word format, indices 1..9 with data 1..9 and flag on 9 → one block_valid pulse; block_sum=45; busy drops the same cycle.
- 4-word format, indices 0..3, data 8'hFF each → block_sum=1020 (0x3FC); no error.
- 9-word format, indices 1,2,4 → block_error pulse after index 4; a following valid 1..9 block still yields block_valid.
- 4-word format, flag_in on index 2 → block_error; missing flag on index 3 → block_error.
- switch_format toggled at index 5 of a 9-word block → block_error; no block_valid; words_received returns to 0.
- Back-to-back: two 4-word blocks with zero gap, then reset asserted at word 2 of a third block → two block_valid pulses (sums checked); after reset all outputs are 0.
